// File: rtl/input_conditioner_if.sv
// Button/frame bundle between the board-level I/O and the input conditioner.
// The master drives the raw buttons and vsync. The slave returns the command vector and the debounced levels.
interface input_conditioner_if;
    logic [4:0] btn_raw;
    logic       vsync;
    logic [4:0] operation;
    logic [4:0] held;

    modport master (
        output btn_raw,
        output vsync,
        input  operation,
        input  held
    );

    modport slave (
        input  btn_raw,
        input  vsync,
        output operation,
        output held
    );
endinterface

// File: rtl/input_conditioner.sv
// Debounces five push-buttons and auto-repeats DOWN/LEFT/RIGHT.
// Presents one command vector per display frame, latched on the vsync rising edge.
module input_conditioner #(
    parameter logic [15:0] DB_LIMIT     = 16'd50000,
    parameter logic [5:0]  REPEAT_DELAY = 6'd16,
    parameter logic [5:0]  REPEAT_RATE  = 6'd4
) (
    input logic                clock,
    input logic                reset,
    input_conditioner_if.slave bus
);

    logic [4:0]  btn_s1;
    logic [4:0]  btn_s2;
    logic        vs_s1;
    logic        vs_s2;
    logic        vs_prev;
    logic [15:0] db_cnt [5];
    logic [5:0]  rep_cnt [3];
    logic [4:0]  held_r;
    logic [4:0]  pending;
    logic [4:0]  operation_r;
    logic [4:0]  press_evt;
    logic [2:0]  repeat_evt;
    logic [4:0]  events;
    logic [4:0]  op_next;
    logic        frame_rise;
    logic        frame_fall;

    assign frame_rise = vs_s2 & ~vs_prev;
    assign frame_fall = ~vs_s2 & vs_prev;

    always_comb begin
        press_evt = '0;
        for (int i = 0; i < 5; i++) begin
            press_evt[i] = btn_s2[i] & ~held_r[i] & (db_cnt[i] == DB_LIMIT - 16'd1);
        end
    end

    always_comb begin
        repeat_evt = '0;
        for (int i = 0; i < 3; i++) begin
            repeat_evt[i] = held_r[i] & frame_fall & ((rep_cnt[i] + 6'd1) == REPEAT_DELAY);
        end
    end

    assign events = press_evt | {2'b00, repeat_evt};

    // START wins outright; simultaneous LEFT+RIGHT cancel each other.
    always_comb begin
        op_next = pending;
        if (pending[4]) begin
            op_next = 5'b10000;
        end else if (pending[1:0] == 2'b11) begin
            op_next = {pending[4:2], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1      <= '0;
            btn_s2      <= '0;
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            vs_prev     <= 1'b0;
            held_r      <= '0;
            pending     <= '0;
            operation_r <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            btn_s1  <= bus.btn_raw;
            btn_s2  <= btn_s1;
            vs_s1   <= bus.vsync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;

            for (int i = 0; i < 5; i++) begin
                if (btn_s2[i] == held_r[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LIMIT - 16'd1) begin
                    held_r[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end

            // After the first repeat, reloading keeps later repeats REPEAT_RATE frames apart.
            for (int i = 0; i < 3; i++) begin
                if (!held_r[i]) begin
                    rep_cnt[i] <= '0;
                end else if (frame_fall) begin
                    if (repeat_evt[i]) begin
                        rep_cnt[i] <= REPEAT_DELAY - REPEAT_RATE;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + 6'd1;
                    end
                end
            end

            // Events raised on the latching cycle carry into the next frame.
            if (frame_rise) begin
                operation_r <= op_next;
                pending     <= events;
            end else begin
                pending     <= pending | events;
            end
        end
    end

    assign bus.held      = held_r;
    assign bus.operation = operation_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner. A frame-level reference model predicts held/operation for every clock.
// A monitor compares the DUT against that prediction. Directed scenarios add fixed-value checks.
module tb_input_conditioner;

    localparam int DB        = 4;
    localparam int RD        = 3;
    localparam int RR        = 2;
    localparam int VS_PERIOD = 16;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;
    bit   vs_run;

    input_conditioner_if dut_if ();

    input_conditioner #(
        .DB_LIMIT     (16'd4),
        .REPEAT_DELAY (6'd3),
        .REPEAT_RATE  (6'd2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [4:0] m_sync_a;
    logic [4:0] m_sync_b;
    logic       m_vs_a;
    logic       m_vs_b;
    logic       m_vs_c;
    logic [4:0] m_held;
    logic [4:0] m_pending;
    logic [4:0] m_op;
    int         frames_held [3];
    logic [4:0] sync_hist [$];
    logic [9:0] exp_q [$];

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at cycle %0d, got no event, expected one", name, cyc);
    endtask

    function automatic logic [4:0] arbitrate(input logic [4:0] p);
        if (p[4]) return 5'b10000;
        if (p[1:0] == 2'b11) return {p[4:2], 2'b00};
        return p;
    endfunction

    // The model works from the rules directly: a level is accepted after DB consecutive synced samples.
    // A held direction repeats on its RD-th frame fall, then again every RR falls.
    task automatic modelStep();
        logic [4:0] ev;
        logic [4:0] held_next;
        logic       rise;
        logic       fall;
        bit         all_one;
        bit         all_zero;
        if (reset) begin
            m_sync_a  = '0;
            m_sync_b  = '0;
            m_vs_a    = 1'b0;
            m_vs_b    = 1'b0;
            m_vs_c    = 1'b0;
            m_held    = '0;
            m_pending = '0;
            m_op      = '0;
            for (int i = 0; i < 3; i++) frames_held[i] = 0;
            sync_hist.delete();
        end else begin
            rise = m_vs_b & ~m_vs_c;
            fall = ~m_vs_b & m_vs_c;
            sync_hist.push_back(m_sync_b);
            if (sync_hist.size() > DB) void'(sync_hist.pop_front());
            ev        = '0;
            held_next = m_held;
            if (sync_hist.size() == DB) begin
                for (int i = 0; i < 5; i++) begin
                    all_one  = 1'b1;
                    all_zero = 1'b1;
                    foreach (sync_hist[k]) begin
                        if (sync_hist[k][i]) all_zero = 1'b0;
                        else all_one = 1'b0;
                    end
                    if (!m_held[i] && all_one) begin
                        held_next[i] = 1'b1;
                        ev[i]        = 1'b1;
                    end
                    if (m_held[i] && all_zero) held_next[i] = 1'b0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!m_held[i]) begin
                    frames_held[i] = 0;
                end else if (fall) begin
                    frames_held[i]++;
                    if (frames_held[i] == RD || (frames_held[i] > RD && (frames_held[i] - RD) % RR == 0))
                        ev[i] = 1'b1;
                end
            end
            if (rise) begin
                m_op      = arbitrate(m_pending);
                m_pending = ev;
            end else begin
                m_pending = m_pending | ev;
            end
            m_held   = held_next;
            m_sync_b = m_sync_a;
            m_sync_a = dut_if.btn_raw;
            m_vs_c   = m_vs_b;
            m_vs_b   = m_vs_a;
            m_vs_a   = dut_if.vsync;
        end
        exp_q.push_back({m_held, m_op});
    endtask

    initial begin
        forever begin
            @(posedge clock);
            modelStep();
        end
    end

    initial begin
        logic [9:0] exp;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checkOutput("sb_held", dut_if.held, exp[9:5]);
                checkOutput("sb_operation", dut_if.operation, exp[4:0]);
            end
        end
    end

    task automatic stepCycle();
        @(negedge clock);
        cyc++;
        if (vs_run) dut_if.vsync = ((cyc % VS_PERIOD) >= VS_PERIOD / 2);
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic applyStimulus(input logic [4:0] btn);
        dut_if.btn_raw = btn;
    endtask

    task automatic alignTo(input int phase);
        for (int i = 0; i < VS_PERIOD && (cyc % VS_PERIOD) != phase; i++) stepCycle();
    endtask

    initial begin
        logic [4:0] btn_val;
        int         idx;
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        vs_run         = 1'b1;
        reset          = 1'b1;
        dut_if.btn_raw = '0;
        dut_if.vsync   = 1'b0;

        stepN(3);
        checkOutput("reset_operation", dut_if.operation, 5'b00000);
        checkOutput("reset_held", dut_if.held, 5'b00000);
        reset = 1'b0;
        stepN(32);
        checkOutput("idle_operation", dut_if.operation, 5'b00000);

        // Single ROTATE press: held after 2 sync + 4 debounce cycles, one frame of 01000.
        applyStimulus(5'b01000);
        stepN(5);
        checkOutput("rotate_held_early", dut_if.held & 5'b01000, 5'b00000);
        stepCycle();
        checkOutput("rotate_held_latency", dut_if.held & 5'b01000, 5'b01000);
        for (int n = 0; n < 40 && dut_if.operation == 5'b00000; n++) stepCycle();
        if (dut_if.operation == 5'b00000) begin
            reportTimeout("rotate_event");
        end else begin
            checkOutput("rotate_operation", dut_if.operation, 5'b01000);
            stepN(VS_PERIOD);
            checkOutput("rotate_next_frame", dut_if.operation, 5'b00000);
        end
        applyStimulus(5'b00000);
        stepN(40);

        // Short glitch on DOWN must never reach held.
        applyStimulus(5'b00100);
        stepN(3);
        applyStimulus(5'b00000);
        stepN(30);
        checkOutput("glitch_held", dut_if.held, 5'b00000);
        checkOutput("glitch_operation", dut_if.operation, 5'b00000);

        // Held DOWN auto-repeats; the scoreboard tracks every frame.
        applyStimulus(5'b00100);
        stepN(10 * VS_PERIOD);
        applyStimulus(5'b00000);
        stepN(3 * VS_PERIOD);

        // LEFT+RIGHT cancel while ROTATE passes through.
        alignTo(9);
        applyStimulus(5'b01011);
        stepN(8);
        applyStimulus(5'b00000);
        alignTo(11);
        checkOutput("left_right_cancel", dut_if.operation, 5'b01000);
        stepN(3 * VS_PERIOD);

        // START overrides DOWN.
        alignTo(9);
        applyStimulus(5'b10100);
        stepN(8);
        applyStimulus(5'b00000);
        alignTo(11);
        checkOutput("start_priority", dut_if.operation, 5'b10000);
        stepN(3 * VS_PERIOD);

        // RIGHT accepted on the very cycle operation latches: shows up one frame later.
        alignTo(5);
        applyStimulus(5'b00001);
        stepN(7);
        checkOutput("boundary_same_frame", dut_if.operation, 5'b00000);
        checkOutput("boundary_held", dut_if.held, 5'b00001);
        applyStimulus(5'b00000);
        stepN(VS_PERIOD);
        checkOutput("boundary_next_frame", dut_if.operation, 5'b00001);
        stepN(3 * VS_PERIOD);

        // Reset while DOWN is repeating, then keep holding it.
        applyStimulus(5'b00100);
        stepN(8 * VS_PERIOD + 3);
        reset = 1'b1;
        stepCycle();
        checkOutput("midrun_reset_operation", dut_if.operation, 5'b00000);
        checkOutput("midrun_reset_held", dut_if.held, 5'b00000);
        reset = 1'b0;
        stepN(8);
        checkOutput("post_reset_held", dut_if.held, 5'b00100);
        stepN(8 * VS_PERIOD);
        applyStimulus(5'b00000);
        stepN(3 * VS_PERIOD);

        // Frozen vsync: operation holds while presses accumulate.
        vs_run = 1'b0;
        applyStimulus(5'b01001);
        stepN(20);
        applyStimulus(5'b00000);
        stepN(20);
        applyStimulus(5'b00010);
        stepN(60);
        applyStimulus(5'b00000);
        vs_run = 1'b1;
        stepN(3 * VS_PERIOD);

        // Randomized button activity with occasional irregular frame lengths.
        btn_val = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idx          = $urandom_range(0, 4);
                btn_val[idx] = ~btn_val[idx];
                applyStimulus(btn_val);
            end
            vs_run = ($urandom_range(0, 49) != 0);
            stepCycle();
        end
        vs_run = 1'b1;
        applyStimulus(5'b00000);
        stepN(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
